sobel_frame_sequencer: RTL and testbench
========================================

# sobel_frame_sequencer

Frame-level controller for the Sobel magnitude datapath. It pulses the datapath start and walks the pixel read address across one frame. It delays that address by the datapath latency to form the magnitude write address, and gates writes to the valid window [STARTADDRESS, ENDADDRESS]. It sits between the frame buffer/address bus and `sobelMag`, and reports busy/done to the top-level particle-detection control.

## Interface
- `IMGWIDTH`, 512, pixels per row (power of two).
- `IMGHEIGHT`, 512, rows per frame.
- `STARTADDRESS`, 770, first address whose magnitude is valid.
- `ENDADDRESS`, 261758, last address read and last valid magnitude address.
- `LATENCY`, 2, cycles from read address to matching `normalisedMag` (1..8).
- `ADDRWIDTH`, 18, address width; must satisfy 2^ADDRWIDTH > ENDADDRESS.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `startEn`  in  1  one-cycle frame start request.
- `stall`  in  1  high freezes all counters and the delay pipe.
- `magStart`  out  1  one-cycle start pulse to `sobelMag` `startEn`.
- `readAddr`  out  ADDRWIDTH  pixel read address to the frame buffer.
- `writeAddr`  out  ADDRWIDTH  magnitude write address.
- `writeEn`  out  1  magnitude write strobe.
- `forceZero`  out  1  write zero instead of `normalisedMag` (border pixel).
- `busy`  out  1  high from the RUN state through the DRAIN state.
- `done`  out  1  one-cycle end-of-frame pulse.

## Operation
- States: IDLE, RUN, DRAIN, DONE. The state register resets to IDLE.
- IDLE: when `startEn`=1, go to RUN, assert `magStart` for that next cycle, and set `readAddr`=0. `startEn` outside IDLE is ignored.
- RUN: on each cycle with `stall`=0, `readAddr` increments by 1. When `readAddr`=ENDADDRESS is accepted (stall=0), go to DRAIN.
- DRAIN: count LATENCY unstalled cycles, then go to DONE.
- DONE: assert `done` for one cycle, then go to IDLE. `readAddr` holds its last value.
- Delay pipe: LATENCY-deep shift register of {address, in-window flag}. It advances only when `stall`=0. The in-window flag is set when STARTADDRESS <= `readAddr` <= ENDADDRESS in RUN.
- `writeAddr` = pipe output address. `writeEn` = pipe output flag AND NOT `stall`.
- Column = address mod IMGWIDTH (low bits). Row/column are never stored separately.
- `stall` in IDLE or DONE has no effect. `stall` in RUN/DRAIN holds all registers, and `writeEn`=0 while held.
- Asserting `reset` mid-frame returns everything to reset values immediately. No partial-frame completion and no `done`.

## Timing
- Reset values: `magStart`=0, `readAddr`=0, `writeAddr`=0, `writeEn`=0, `forceZero`=0, `busy`=0, `done`=0; pipe cleared.
- Cycle T: `startEn` is sampled high. At T+1: `magStart`=1, `busy`=1, `readAddr`=0.
- With no stall, the write for address A has `writeEn` high exactly LATENCY cycles after `readAddr`=A.
- Unstalled frame: `done` is high ENDADDRESS+LATENCY+2 cycles after the `startEn` cycle.
- `busy` falls in the same cycle `done` rises.
- Back-to-back: `startEn` in the DONE cycle is ignored. `startEn` is accepted from the following IDLE cycle.

## Configuration
- `SOBEL_SEQ_BORDER_ZERO_EN` defined: `forceZero` = `writeEn` AND (column of `writeAddr` is 0 or IMGWIDTH-1). Border pixels are still written, as zero.
- Not defined: `forceZero` is tied 0 and border pixels carry `normalisedMag` unchanged.

## Structure
- Shared package `sobel_pkg`:
  - state enum `seq_state_t` {IDLE, RUN, DRAIN, DONE};
  - default image constants (IMGWIDTH, IMGHEIGHT, STARTADDRESS, ENDADDRESS);
  - address width.
- One sub-module, `sobel_addr_delay`: parameterised LATENCY-deep, stall-gated shift register carrying {address, flag}.

## Test plan
All scenarios use IMGWIDTH=8, IMGHEIGHT=4, STARTADDRESS=9, ENDADDRESS=22, LATENCY=2.
- Reset/idle: hold `reset`=0 then release, apply no start -> all outputs 0 for 20 cycles.
- Plain frame: `startEn` pulse at cycle 0 -> `magStart` at 1; `readAddr` 0..22 over cycles 1..23; `writeEn` high for `writeAddr` 9..22 at cycles 12..25; `done` at cycle 26.
- Stall: `stall` high for 3 cycles while `readAddr`=12 -> `readAddr` holds 12, `writeEn`=0 during the stall, no address skipped or repeated, `done` at cycle 29.
- Ignored start: `startEn` at `readAddr`=5 and in the DONE cycle -> no restart, single `done`; restart succeeds the cycle after.
- Border: with the macro defined, `writeAddr` 15, 16, 23-range columns 7/0 (addresses 15, 16) -> `forceZero`=1; address 10 -> 0. Without the macro, `forceZero` always 0.
- Mid-frame reset: `reset` low at `readAddr`=14 -> outputs 0 asynchronously, state IDLE, no `done`; a new `startEn` runs a full frame.

Source files
------------

// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Shared types and default constants for the Sobel frame sequencing logic.
//   seq_state_t       : frame sequencer state encoding
//   DEFAULT_*         : default image geometry and valid-magnitude window
//   DEFAULT_ADDRWIDTH : default frame buffer address width
//   DRAINCNTWIDTH     : width of the drain counter (covers latencies 1..8)
// -----------------------------------------------------------------------------
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int DEFAULT_IMGWIDTH     = 512;
    localparam int DEFAULT_IMGHEIGHT    = 512;
    localparam int DEFAULT_STARTADDRESS = 770;
    localparam int DEFAULT_ENDADDRESS   = 261758;
    localparam int DEFAULT_LATENCY      = 2;
    localparam int DEFAULT_ADDRWIDTH    = 18;

    localparam int DRAINCNTWIDTH = 4;

endpackage

// File: rtl/sobel_addr_delay.sv
// -----------------------------------------------------------------------------
// sobel_addr_delay
// LATENCY-deep shift register carrying {address, flag}. It lines a read
// address up with the magnitude the datapath produces for it. The pipe only
// moves when advance is high, so a stalled frame keeps its alignment.
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-low reset (clears every stage)
//   advance  in   shift enable
//   addrIn   in   address entering the pipe
//   flagIn   in   flag entering the pipe
//   addrOut  out  address leaving the pipe (last stage)
//   flagOut  out  flag leaving the pipe (last stage)
// -----------------------------------------------------------------------------
module sobel_addr_delay
    import sobel_pkg::*;
#(
    parameter int ADDRWIDTH = DEFAULT_ADDRWIDTH,
    parameter int LATENCY   = DEFAULT_LATENCY
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 advance,
    input  logic [ADDRWIDTH-1:0] addrIn,
    input  logic                 flagIn,
    output logic [ADDRWIDTH-1:0] addrOut,
    output logic                 flagOut
);

    logic [ADDRWIDTH-1:0] addrPipe_q [LATENCY];
    logic                 flagPipe_q [LATENCY];

    // Stage 0 takes the new entry and every later stage takes its
    // predecessor, all in one step and only while advance is high. Reset
    // empties the whole pipe so no stale write can appear after a restart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                addrPipe_q[i] <= '0;
                flagPipe_q[i] <= 1'b0;
            end
        end else if (advance) begin
            addrPipe_q[0] <= addrIn;
            flagPipe_q[0] <= flagIn;
            for (int i = 1; i < LATENCY; i++) begin
                addrPipe_q[i] <= addrPipe_q[i-1];
                flagPipe_q[i] <= flagPipe_q[i-1];
            end
        end
    end

    assign addrOut = addrPipe_q[LATENCY-1];
    assign flagOut = flagPipe_q[LATENCY-1];

endmodule

// File: rtl/sobel_frame_sequencer.sv
// -----------------------------------------------------------------------------
// sobel_frame_sequencer
// Frame-level controller for the Sobel magnitude datapath. It pulses the
// datapath start, walks the read address across one frame, delays that
// address by the datapath latency to form the write address, and gates
// writes to the valid window [STARTADDRESS, ENDADDRESS].
// Optional build macro: SOBEL_SEQ_BORDER_ZERO_EN. When it is defined,
// forceZero flags writes in column 0 and column IMGWIDTH-1. When it is not
// defined, forceZero is tied low.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   startEn    in   one-cycle frame start request (used only in IDLE)
//   stall      in   freezes counters and the delay pipe in RUN/DRAIN
//   magStart   out  one-cycle start pulse to the magnitude datapath
//   readAddr   out  pixel read address to the frame buffer
//   writeAddr  out  magnitude write address (read address delayed)
//   writeEn    out  magnitude write strobe
//   forceZero  out  write zero instead of the magnitude (border pixel)
//   busy       out  high in RUN and DRAIN
//   done       out  one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module sobel_frame_sequencer
    import sobel_pkg::*;
#(
    parameter int IMGWIDTH     = DEFAULT_IMGWIDTH,
    parameter int IMGHEIGHT    = DEFAULT_IMGHEIGHT,
    parameter int STARTADDRESS = DEFAULT_STARTADDRESS,
    parameter int ENDADDRESS   = DEFAULT_ENDADDRESS,
    parameter int LATENCY      = DEFAULT_LATENCY,
    parameter int ADDRWIDTH    = DEFAULT_ADDRWIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startEn,
    input  logic                 stall,
    output logic                 magStart,
    output logic [ADDRWIDTH-1:0] readAddr,
    output logic [ADDRWIDTH-1:0] writeAddr,
    output logic                 writeEn,
    output logic                 forceZero,
    output logic                 busy,
    output logic                 done
);

    // Reject geometries the address logic cannot represent.
    if (LATENCY < 1 || LATENCY > 8) begin : gLatencyCheck
        $error("sobel_frame_sequencer: LATENCY must be within 1..8");
    end
    if (longint'(ENDADDRESS) >= (64'd1 << ADDRWIDTH)) begin : gWidthCheck
        $error("sobel_frame_sequencer: ADDRWIDTH too narrow for ENDADDRESS");
    end
    if (longint'(ENDADDRESS) >= longint'(IMGWIDTH) * longint'(IMGHEIGHT)) begin : gFrameCheck
        $error("sobel_frame_sequencer: ENDADDRESS lies outside the frame");
    end

    localparam logic [ADDRWIDTH-1:0]     LASTADDR  = ADDRWIDTH'(ENDADDRESS);
    localparam logic [ADDRWIDTH-1:0]     FIRSTADDR = ADDRWIDTH'(STARTADDRESS);
    localparam logic [DRAINCNTWIDTH-1:0] DRAINLAST = DRAINCNTWIDTH'(LATENCY - 1);

    seq_state_t state_q, state_d;

    logic [ADDRWIDTH-1:0]     readAddr_q, readAddr_d;
    logic [DRAINCNTWIDTH-1:0] drainCnt_q, drainCnt_d;
    logic                     magStart_q, magStart_d;

    logic                 inWindow;
    logic                 pipeAdvance;
    logic [ADDRWIDTH-1:0] pipeAddr;
    logic                 pipeFlag;

    // State register. Reset drops straight back to IDLE, abandoning any
    // frame in flight without passing through DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. RUN leaves once the last address has been issued on
    // an unstalled cycle. DRAIN then waits LATENCY unstalled cycles so the
    // final write clears the delay pipe before done is raised. DONE lasts
    // exactly one cycle and ignores startEn.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (startEn) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!stall && readAddr_q == LASTADDR) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!stall && drainCnt_q == DRAINLAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Counter updates. Accepting a start rewinds the read address to zero and
    // sets up the one-cycle magStart pulse. While running, the address stops
    // at the last frame address and stays there until the next start.
    always_comb begin
        readAddr_d = readAddr_q;
        drainCnt_d = drainCnt_q;
        magStart_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (startEn) begin
                    readAddr_d = '0;
                    drainCnt_d = '0;
                    magStart_d = 1'b1;
                end
            end
            RUN: begin
                if (!stall && readAddr_q != LASTADDR) begin
                    readAddr_d = readAddr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (!stall) begin
                    drainCnt_d = drainCnt_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readAddr_q <= '0;
            drainCnt_q <= '0;
            magStart_q <= 1'b0;
        end else begin
            readAddr_q <= readAddr_d;
            drainCnt_q <= drainCnt_d;
            magStart_q <= magStart_d;
        end
    end

    // Output decode. busy and done come straight from the state, so busy
    // falls in the same cycle that done rises. The pipe freezes on stall only
    // inside a frame, which keeps stall harmless in IDLE and DONE.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            RUN, DRAIN: busy = 1'b1;
            DONE:       done = 1'b1;
            default: begin
            end
        endcase
        inWindow    = (state_q == RUN) && (readAddr_q >= FIRSTADDR) &&
                      (readAddr_q <= LASTADDR);
        pipeAdvance = !(stall && busy);
        magStart    = magStart_q;
        readAddr    = readAddr_q;
        writeAddr   = pipeAddr;
        writeEn     = pipeFlag && !stall;
    end

    sobel_addr_delay #(
        .ADDRWIDTH (ADDRWIDTH),
        .LATENCY   (LATENCY)
    ) uAddrDelay (
        .clk     (clk),
        .reset   (reset),
        .advance (pipeAdvance),
        .addrIn  (readAddr_q),
        .flagIn  (inWindow),
        .addrOut (pipeAddr),
        .flagOut (pipeFlag)
    );

`ifdef SOBEL_SEQ_BORDER_ZERO_EN
    localparam int COLBITS = $clog2(IMGWIDTH);

    logic [COLBITS-1:0] writeCol;

    // IMGWIDTH is a power of two, so the column is the low address bits.
    // Border pixels are still written, just as zero.
    always_comb begin
        writeCol  = pipeAddr[COLBITS-1:0];
        forceZero = writeEn &&
                    ((writeCol == '0) || (writeCol == COLBITS'(IMGWIDTH - 1)));
    end
`else
    assign forceZero = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sobel_frame_sequencer
// Directed bench for sobel_frame_sequencer on an 8x4 frame with window 9..22
// and latency 2. Expected values are worked out by hand per cycle, counting
// from the cycle in which startEn is sampled (cycle 0).
// -----------------------------------------------------------------------------
module tb_sobel_frame_sequencer;

    localparam int IMGW  = 8;
    localparam int IMGH  = 4;
    localparam int SADDR = 9;
    localparam int EADDR = 22;
    localparam int LAT   = 2;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          startEn;
    logic          stall;
    logic          magStart;
    logic [AW-1:0] readAddr;
    logic [AW-1:0] writeAddr;
    logic          writeEn;
    logic          forceZero;
    logic          busy;
    logic          done;

    int compared   = 0;
    int mismatched = 0;
    int writeCount = 0;

    sobel_frame_sequencer #(
        .IMGWIDTH     (IMGW),
        .IMGHEIGHT    (IMGH),
        .STARTADDRESS (SADDR),
        .ENDADDRESS   (EADDR),
        .LATENCY      (LAT),
        .ADDRWIDTH    (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .startEn   (startEn),
        .stall     (stall),
        .magStart  (magStart),
        .readAddr  (readAddr),
        .writeAddr (writeAddr),
        .writeEn   (writeEn),
        .forceZero (forceZero),
        .busy      (busy),
        .done      (done)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: count it, and on a difference count and report it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d required %0d", tag, observed, expected);
        end
    endtask

    // Drive this cycle's inputs and let the combinational outputs settle.
    task automatic applyStimulus(input logic s, input logic st);
        startEn = s;
        stall   = st;
        #1;
    endtask

    // Move to 1 ns after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Border flag the sequencer should show for a write to address a.
    function automatic logic expForce(input int a, input logic we);
`ifdef SOBEL_SEQ_BORDER_ZERO_EN
        return we && (((a % IMGW) == 0) || ((a % IMGW) == IMGW - 1));
`else
        return 1'b0;
`endif
    endfunction

    // Compare every frame output against one cycle's expectations.
    task automatic checkFrame(input string tag, input logic eMag, input int eRead,
                              input logic eBusy, input logic eDone,
                              input logic eWe, input int eWa);
        checkOutput({tag, " magStart"}, 32'(magStart), 32'(eMag));
        checkOutput({tag, " readAddr"}, 32'(readAddr), 32'(eRead));
        checkOutput({tag, " busy"}, 32'(busy), 32'(eBusy));
        checkOutput({tag, " done"}, 32'(done), 32'(eDone));
        checkOutput({tag, " writeEn"}, 32'(writeEn), 32'(eWe));
        if (eWe) begin
            checkOutput({tag, " writeAddr"}, 32'(writeAddr), 32'(eWa));
        end
        checkOutput({tag, " forceZero"}, 32'(forceZero), 32'(expForce(eWa, eWe)));
    endtask

    // Expectations for cycle c of an unstalled frame: reads 0..22 over
    // cycles 1..23, writes 9..22 over cycles 12..25, done at cycle 26.
    task automatic checkPlainCycle(input string tag, input int c);
        checkFrame($sformatf("%s c%0d", tag, c), c == 1, (c <= 23) ? c - 1 : 22,
                   (c >= 1) && (c <= 25), c == 26, (c >= 12) && (c <= 25), c - 3);
    endtask

    // All outputs packed together; every one of them should be zero.
    function automatic logic [31:0] allOutputs();
        return 32'({magStart, readAddr, writeAddr, writeEn, forceZero, busy, done});
    endfunction

    initial begin
        int eRead;
        int eWa;
        logic eWe;

        reset   = 1'b0;
        startEn = 1'b0;
        stall   = 1'b0;

        // Held in reset: everything zero.
        nextCycle();
        nextCycle();
        checkOutput("in reset outputs", allOutputs(), 32'd0);

        // Released, no start, even with stall toggling: idle stays quiet.
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, i[2]);
            checkOutput($sformatf("idle c%0d outputs", i), allOutputs(), 32'd0);
            nextCycle();
        end

        // Plain frame.
        applyStimulus(1'b1, 1'b0);
        checkOutput("plain c0 busy", 32'(busy), 32'd0);
        nextCycle();
        for (int c = 1; c <= 27; c++) begin
            applyStimulus(1'b0, 1'b0);
            checkPlainCycle("plain", c);
            nextCycle();
        end

        // Stall for cycles 13..15 while readAddr is 12: every later read and
        // write slips three cycles and done moves to cycle 29.
        applyStimulus(1'b1, 1'b0);
        nextCycle();
        for (int c = 1; c <= 30; c++) begin
            applyStimulus(1'b0, (c >= 13) && (c <= 15));
            if (c <= 13)      eRead = c - 1;
            else if (c <= 16) eRead = 12;
            else if (c <= 26) eRead = c - 4;
            else              eRead = 22;
            eWe = (c == 12) || ((c >= 16) && (c <= 28));
            eWa = (c == 12) ? 9 : c - 6;
            checkFrame($sformatf("stall c%0d", c), c == 1, eRead,
                       (c >= 1) && (c <= 28), c == 29, eWe, eWa);
            nextCycle();
        end

        // startEn at readAddr 5 and in the DONE cycle is ignored; the start
        // in the following IDLE cycle is taken.
        applyStimulus(1'b1, 1'b0);
        nextCycle();
        for (int c = 1; c <= 27; c++) begin
            applyStimulus((c == 6) || (c == 26) || (c == 27), 1'b0);
            checkPlainCycle("ignored", c);
            nextCycle();
        end

        // Restarted frame, cut short by reset while readAddr is 14.
        for (int c = 1; c <= 15; c++) begin
            applyStimulus(1'b0, 1'b0);
            checkPlainCycle("restart", c);
            if (c < 15) nextCycle();
        end
        reset = 1'b0;
        #1;
        checkOutput("async reset outputs", allOutputs(), 32'd0);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput($sformatf("held reset c%0d outputs", i), allOutputs(), 32'd0);
        end

        // After release, a new start runs a whole frame with fourteen writes.
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("post reset c0 busy", 32'(busy), 32'd0);
        nextCycle();
        for (int c = 1; c <= 27; c++) begin
            applyStimulus(1'b0, 1'b0);
            checkPlainCycle("post reset", c);
            if (writeEn) writeCount++;
            nextCycle();
        end
        checkOutput("post reset write count", 32'(writeCount), 32'(EADDR - SADDR + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
